// File: rtl/uart_tx.sv
// Purpose : 8N1 UART transmitter; accepts one byte per request and serialises it LSB first.
// Latency : first start-bit cycle follows the accepting edge; o_tx_done pulses 10*CLKS_PER_BIT+1 cycles later.
// Flow    : i_tx_start is a level-held, active-low request; it is only sampled in IDLE, so a request
//           still held during DONE is not re-accepted for the same byte.
//
// Ports:
//   i_clk       single clock, all state changes on the rising edge
//   i_reset     asynchronous active-high reset; aborts any frame with the line forced idle-high
//   i_tx_start  active-low send request, held by the requester until it sees o_tx_done
//   i_tx_data   byte to send, captured only at frame acceptance
//   o_tx        registered serial line, idle high
//   o_tx_done   single-cycle pulse once the stop bit has fully gone out
//   o_busy      high from the cycle after acceptance through the o_tx_done cycle
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tx_start,
   input  logic [7:0] i_tx_data,
   output logic       o_tx,
   output logic       o_tx_done,
   output logic       o_busy
);

   // Terminal value of the 16-bit baud counter.
   localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_baud;
   logic [15:0] w_baud_nxt;
   logic [2:0]  r_bit_idx;
   logic [2:0]  w_bit_idx_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic        r_tx;
   logic        w_tx_nxt;
   logic        r_tx_done;
   logic        r_busy;
   logic        w_bit_end;

   // Last clock of the current serial bit.
   assign w_bit_end = (r_baud == LP_BAUD_LAST);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, counters and shift register
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;

      unique case (r_state)
         S_IDLE: begin
            if (!i_tx_start) begin
               w_state_nxt   = S_START;
               w_shift_nxt   = i_tx_data;
               w_baud_nxt    = 16'd0;
               w_bit_idx_nxt = 3'd0;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = 16'd0;
            end else begin
               w_baud_nxt = r_baud + 16'd1;
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt  = 16'd0;
               // The line always shows r_shift[0]; shifting right presents the next bit.
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt   = S_STOP;
                  w_bit_idx_nxt = 3'd0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud + 16'd1;
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = S_DONE;
               w_baud_nxt  = 16'd0;
            end else begin
               w_baud_nxt = r_baud + 16'd1;
            end
         end

         S_DONE: begin
            // One cycle only; the request input is deliberately not looked at here.
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode from the *next* state so every output is a flop that
   // lines up with the state it describes (no decode glitches on o_tx).
   // ------------------------------------------------------------------
   always_comb begin
      w_tx_nxt = 1'b1;
      unique case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_baud    <= 16'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
         r_tx_done <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
         r_tx_done <= (w_state_nxt == S_DONE);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign o_tx      = r_tx;
   assign o_tx_done = r_tx_done;
   assign o_busy    = r_busy;

   // DONE always falls straight back to IDLE, so the pulse can never stretch.
   a_done_single : assert property (@(posedge i_clk) disable iff (i_reset)
      r_tx_done |=> !r_tx_done);

   a_baud_range : assert property (@(posedge i_clk) disable iff (i_reset)
      r_baud <= LP_BAUD_LAST);

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   localparam int CPB    = 4;
   localparam int FRAME  = 10 * CPB + 1;   // cycles from first start-bit cycle to tx_done cycle
   localparam int PERIOD = FRAME + 1;      // back-to-back frame period (adds the IDLE cycle)

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_tx_start;
   logic [7:0] i_tx_data;
   logic       o_tx;
   logic       o_tx_done;
   logic       o_busy;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic tx;
      logic done;
      logic busy;
   } obs_t;

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_bits;   // {stop, d7..d0, start}, bit 0 goes out first
      bit         toggle;
      string      name;
   } vec_t;

   obs_t       exp_q[$];
   logic [7:0] b2b_q[$];

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_tx_start (i_tx_start),
      .i_tx_data  (i_tx_data),
      .o_tx       (o_tx),
      .o_tx_done  (o_tx_done),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle line: tx high, no done, not busy, for n cycles; request kept released.
   task automatic check_idle(input int n, input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         step();
         i_tx_start = 1'b1;
         if ({o_tx, o_tx_done, o_busy} !== 3'b100) bad++;
      end
      check(name, bad, 0);
   endtask

   // Reference waveform for one frame followed by its DONE and IDLE cycles.
   function automatic void model_frame(input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int s = 0; s < 10; s++)
         for (int k = 0; k < CPB; k++)
            exp_q.push_back(obs_t'({bits[s], 1'b0, 1'b1}));
      exp_q.push_back(obs_t'(3'b111));
      exp_q.push_back(obs_t'(3'b100));
   endfunction

   // One frame from IDLE; expected bit slots come from the caller's table.
   task automatic send_frame(input logic [7:0] data, input logic [9:0] exp_bits,
                             input bit toggle, input bit pulse_done, input string name);
      logic [CPB-1:0]   slot_pat[10];
      logic [FRAME-1:0] done_v;
      logic [FRAME-1:0] busy_v;
      logic [FRAME-1:0] done_exp;
      logic [7:0]       rx;
      int slot, k;
      rx       = '0;
      done_v   = '0;
      busy_v   = '0;
      done_exp = '0;
      done_exp[FRAME-1] = 1'b1;
      for (int s = 0; s < 10; s++) slot_pat[s] = '0;
      i_tx_data  = data;
      i_tx_start = 1'b0;
      for (int c = 1; c <= FRAME; c++) begin
         step();
         done_v[c-1] = o_tx_done;
         busy_v[c-1] = o_busy;
         if (c <= 10 * CPB) begin
            slot = (c - 1) / CPB;
            k    = (c - 1) % CPB;
            slot_pat[slot][k] = o_tx;
            if (slot >= 1 && slot <= 8 && k == CPB / 2) rx[slot-1] = o_tx;
         end else begin
            check($sformatf("%s_done_tx", name), o_tx, 1'b1);
         end
         if (toggle) i_tx_data = ~i_tx_data;
         if (c == 1 && pulse_done) i_tx_start = 1'b1;
         if (c == FRAME) i_tx_start = pulse_done ? 1'b0 : 1'b1;
      end
      for (int s = 0; s < 10; s++)
         check($sformatf("%s_slot%0d", name, s), slot_pat[s], {CPB{exp_bits[s]}});
      check($sformatf("%s_done", name), done_v, done_exp);
      check($sformatf("%s_busy", name), busy_v, {FRAME{1'b1}});
      check($sformatf("%s_rx", name), rx, data);
   endtask

   // Request held low across all frames of b2b_q; next byte presented in the cycle after tx_done.
   task automatic run_b2b(input bit junk, input string name);
      int   nf, total, dones, frame, pos;
      obs_t got;
      logic [7:0] rx;
      exp_q.delete();
      foreach (b2b_q[i]) model_frame(b2b_q[i]);
      for (int i = 0; i < 20; i++) exp_q.push_back(obs_t'(3'b100));
      nf    = b2b_q.size();
      total = exp_q.size();
      dones = 0;
      rx    = '0;
      i_tx_data  = b2b_q[0];
      i_tx_start = 1'b0;
      for (int c = 1; c <= total; c++) begin
         step();
         got = {o_tx, o_tx_done, o_busy};
         if (o_tx_done === 1'b1) dones++;
         check($sformatf("%s_c%0d", name, c), got, exp_q[c-1]);
         frame = (c - 1) / PERIOD;
         pos   = (c - 1) % PERIOD + 1;
         if (frame < nf) begin
            for (int j = 0; j < 8; j++)
               if (pos == (j + 1) * CPB + CPB / 2 + 1) rx[j] = o_tx;
            if (pos == FRAME) check($sformatf("%s_rx%0d", name, frame), rx, b2b_q[frame]);
            if (pos == PERIOD) begin
               if (frame + 1 < nf) i_tx_data = b2b_q[frame+1];
               else i_tx_start = 1'b1;
            end else if (junk) begin
               i_tx_data = 8'($urandom);
            end
         end
      end
      check($sformatf("%s_dones", name), dones, nf);
   endtask

   initial begin
      vec_t vecs[7];
      bit   done_seen;

      vecs[0] = '{8'hA5, 10'h34A, 1'b0, "a5"};
      vecs[1] = '{8'h00, 10'h200, 1'b0, "x00"};
      vecs[2] = '{8'hFF, 10'h3FE, 1'b0, "xff"};
      vecs[3] = '{8'h3C, 10'h278, 1'b1, "x3c_toggle"};
      vecs[4] = '{8'h01, 10'h202, 1'b0, "x01"};
      vecs[5] = '{8'h80, 10'h300, 1'b0, "x80"};
      vecs[6] = '{8'h55, 10'h2AA, 1'b1, "x55_toggle"};

      i_reset    = 1'b0;
      i_tx_start = 1'b1;
      i_tx_data  = 8'h00;
      #2 i_reset = 1'b1;
      #1 check("reset_async", {o_tx, o_tx_done, o_busy}, 3'b100);
      repeat (2) step();
      check("reset_held", {o_tx, o_tx_done, o_busy}, 3'b100);
      i_reset = 1'b0;

      check_idle(100, "idle_100_after_reset");

      for (int v = 0; v < 7; v++) begin
         send_frame(vecs[v].data, vecs[v].exp_bits, vecs[v].toggle, 1'b0, vecs[v].name);
         check_idle(3, {vecs[v].name, "_no_reaccept"});
      end

      // Request seen low only in the DONE cycle must not start a frame.
      send_frame(8'h96, 10'h32C, 1'b0, 1'b1, "x96");
      check_idle(60, "done_cycle_request_ignored");

      b2b_q = '{8'h01, 8'h02};
      run_b2b(1'b0, "b2b_0102");

      b2b_q.delete();
      for (int i = 0; i < 8; i++) b2b_q.push_back(8'($urandom));
      run_b2b(1'b1, "b2b_rand");

      // Reset during data bit 3 (0xF0 has bit 3 low, so the forced-high line is visible).
      done_seen  = 1'b0;
      i_tx_data  = 8'hF0;
      i_tx_start = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         step();
         if (c == 1) i_tx_start = 1'b1;
         if (o_tx_done === 1'b1) done_seen = 1'b1;
      end
      check("mid_bit3_tx_low", o_tx, 1'b0);
      check("mid_no_done_before_reset", done_seen, 1'b0);
      i_reset = 1'b1;
      #1 check("mid_reset_async", {o_tx, o_tx_done, o_busy}, 3'b100);
      step();
      check("mid_reset_held", {o_tx, o_tx_done, o_busy}, 3'b100);
      i_reset = 1'b0;
      check_idle(60, "after_mid_reset_idle");

      // Acceptance on the very first edge after reset release.
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      send_frame(8'hC3, 10'h386, 1'b0, 1'b0, "first_edge_xc3");
      check_idle(5, "final_idle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
